// File: rtl/result_matrix_collector.sv
// Collects (z_out, z_i, z_j) results into an M x M buffer, then streams the matrix out row-major.
// Define RESULT_DUP_DETECT_EN to track filled entries and flag duplicate writes on dup_err.
module result_matrix_collector #(
  parameter int M     = 4,
  parameter int W     = 32,
  parameter int IDX_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     z_out,
  input  logic [IDX_W-1:0] z_i,
  input  logic [IDX_W-1:0] z_j,
  input  logic             z_stb,
  output logic             z_ack,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             idx_err,
  output logic             dup_err
);

  localparam int N     = M * M;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PTR_W = $clog2(N);

  // state     | meaning
  // S_COLLECT | accepting result words until every entry is held
  // S_DRAIN   | streaming buffer out row-major on out_valid/out_ready
  // S_DONE    | drain complete, producer back-pressured until rst
  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       mem [N];
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   wr_addr;
  logic               in_range;
  logic               capture;
  logic               wr_en;
  logic               cnt_inc;
`ifdef RESULT_DUP_DETECT_EN
  logic [N-1:0]       filled;
  logic               dup_hit;
`endif

  assign in_range = (int'(z_i) < M) && (int'(z_j) < M);
  assign wr_addr  = PTR_W'(int'(z_i) * M + int'(z_j));

  // Row-major index p maps directly onto the flat buffer address i*M+j.
  assign out_data = mem[ptr];

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    wr_en     = 1'b0;
    cnt_inc   = 1'b0;
`ifdef RESULT_DUP_DETECT_EN
    dup_hit   = 1'b0;
`endif
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_COLLECT: begin
        // z_ack high blocks capture so a strobe held one extra cycle is not rewritten.
        if (z_stb && !z_ack) begin
          capture = 1'b1;
          if (in_range) begin
            wr_en = !rst;
`ifdef RESULT_DUP_DETECT_EN
            dup_hit = filled[wr_addr];
            cnt_inc = !filled[wr_addr];
`else
            cnt_inc = 1'b1;
`endif
          end
        end
        if (cnt_inc && count == CNT_W'(N - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (ptr == PTR_W'(N - 1));
        if (out_ready && out_last) state_nxt = S_DONE;
      end
      S_DONE: done = 1'b1;
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_COLLECT;
      z_ack   <= 1'b0;
      count   <= '0;
      ptr     <= '0;
      idx_err <= 1'b0;
`ifdef RESULT_DUP_DETECT_EN
      filled  <= '0;
      dup_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      z_ack <= capture;
      if (cnt_inc) count <= count + 1'b1;
      if (out_valid && out_ready && !out_last) ptr <= ptr + 1'b1;
      if (capture && !in_range) idx_err <= 1'b1;
`ifdef RESULT_DUP_DETECT_EN
      if (wr_en) filled[wr_addr] <= 1'b1;
      if (dup_hit) dup_err <= 1'b1;
`endif
    end
  end

`ifndef RESULT_DUP_DETECT_EN
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= z_out;
  end

endmodule
